decoder: RTL and testbench

Decode stage of the RV32I out-of-order core. Pops one 32-bit instruction and its PC per cycle from the instruction queue and expands it into opcode class, register indices and a sign-extended immediate. Results are held in a single output register and handed to the reservation-station/ROB dispatch logic under a valid/stall handshake. The whole stage is flushed when the ROB signals an exception or mispredict.

---
 rtl/decoder.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// RV32I decode stage: pops one instruction per cycle from the instruction queue,
// expands it into op class, register indices and immediate, and holds the result
// in a single output register handed to dispatch under a valid/stall handshake.
module decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        is_empty_from_iq,
   input  logic [31:0] instr_from_iq,
   input  logic [31:0] pc_from_iq,
   input  logic        is_stall_from_rs,
   input  logic        is_exception_from_rob,
   output logic        is_receive_to_iq,
   output logic        is_instr_to_rs,
   output logic [5:0]  op_to_rs,
   output logic [4:0]  rd_to_rs,
   output logic [4:0]  rs1_to_rs,
   output logic [4:0]  rs2_to_rs,
   output logic [31:0] imm_to_rs,
   output logic [31:0] pc_to_rs
);

   // Major opcodes
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;

   // Only two funct7 values are legal; the alternate one selects SUB/SRA/SRAI
   localparam logic [6:0] F7Base = 7'b0000000;
   localparam logic [6:0] F7Alt  = 7'b0100000;

   // Decoded operation codes seen by dispatch
   localparam logic [5:0] OpInvalid = 6'd0;
   localparam logic [5:0] OpLui     = 6'd1;
   localparam logic [5:0] OpAuipc   = 6'd2;
   localparam logic [5:0] OpJal     = 6'd3;
   localparam logic [5:0] OpJalr    = 6'd4;
   localparam logic [5:0] OpBeq     = 6'd5;
   localparam logic [5:0] OpBne     = 6'd6;
   localparam logic [5:0] OpBlt     = 6'd7;
   localparam logic [5:0] OpBge     = 6'd8;
   localparam logic [5:0] OpBltu    = 6'd9;
   localparam logic [5:0] OpBgeu    = 6'd10;
   localparam logic [5:0] OpLb      = 6'd11;
   localparam logic [5:0] OpLh      = 6'd12;
   localparam logic [5:0] OpLw      = 6'd13;
   localparam logic [5:0] OpLbu     = 6'd14;
   localparam logic [5:0] OpLhu     = 6'd15;
   localparam logic [5:0] OpSb      = 6'd16;
   localparam logic [5:0] OpSh      = 6'd17;
   localparam logic [5:0] OpSw      = 6'd18;
   localparam logic [5:0] OpAddi    = 6'd19;
   localparam logic [5:0] OpSlti    = 6'd20;
   localparam logic [5:0] OpSltiu   = 6'd21;
   localparam logic [5:0] OpXori    = 6'd22;
   localparam logic [5:0] OpOri     = 6'd23;
   localparam logic [5:0] OpAndi    = 6'd24;
   localparam logic [5:0] OpSlli    = 6'd25;
   localparam logic [5:0] OpSrli    = 6'd26;
   localparam logic [5:0] OpSrai    = 6'd27;
   localparam logic [5:0] OpAdd     = 6'd28;
   localparam logic [5:0] OpSub     = 6'd29;
   localparam logic [5:0] OpSll     = 6'd30;
   localparam logic [5:0] OpSlt     = 6'd31;
   localparam logic [5:0] OpSltu    = 6'd32;
   localparam logic [5:0] OpXor     = 6'd33;
   localparam logic [5:0] OpSrl     = 6'd34;
   localparam logic [5:0] OpSra     = 6'd35;
   localparam logic [5:0] OpOr      = 6'd36;
   localparam logic [5:0] OpAnd     = 6'd37;

   // Instruction format drives which fields and which immediate are exposed
   typedef enum logic [2:0] {
      FmtNone,
      FmtR,
      FmtI,
      FmtSh,
      FmtS,
      FmtB,
      FmtU,
      FmtJ
   } fmt_e;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   logic [5:0]  dec_op;
   fmt_e        dec_fmt;
   fmt_e        cand_fmt;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [31:0] dec_imm;

   logic        take;

   logic        valid_q, valid_d;
   logic [5:0]  op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   logic [4:0]  rs1_q, rs1_d;
   logic [4:0]  rs2_q, rs2_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] pc_q, pc_d;

   assign opcode = instr_from_iq[6:0];
   assign funct3 = instr_from_iq[14:12];
   assign funct7 = instr_from_iq[31:25];

   // Classify the instruction into an op code and its encoding format
   always_comb begin
      dec_op   = OpInvalid;
      cand_fmt = FmtNone;
      case (opcode)
         OpcLui: begin
            dec_op   = OpLui;
            cand_fmt = FmtU;
         end
         OpcAuipc: begin
            dec_op   = OpAuipc;
            cand_fmt = FmtU;
         end
         OpcJal: begin
            dec_op   = OpJal;
            cand_fmt = FmtJ;
         end
         OpcJalr: begin
            cand_fmt = FmtI;
            if (funct3 == 3'b000) dec_op = OpJalr;
         end
         OpcBranch: begin
            cand_fmt = FmtB;
            case (funct3)
               3'b000:  dec_op = OpBeq;
               3'b001:  dec_op = OpBne;
               3'b100:  dec_op = OpBlt;
               3'b101:  dec_op = OpBge;
               3'b110:  dec_op = OpBltu;
               3'b111:  dec_op = OpBgeu;
               default: dec_op = OpInvalid;
            endcase
         end
         OpcLoad: begin
            cand_fmt = FmtI;
            case (funct3)
               3'b000:  dec_op = OpLb;
               3'b001:  dec_op = OpLh;
               3'b010:  dec_op = OpLw;
               3'b100:  dec_op = OpLbu;
               3'b101:  dec_op = OpLhu;
               default: dec_op = OpInvalid;
            endcase
         end
         OpcStore: begin
            cand_fmt = FmtS;
            case (funct3)
               3'b000:  dec_op = OpSb;
               3'b001:  dec_op = OpSh;
               3'b010:  dec_op = OpSw;
               default: dec_op = OpInvalid;
            endcase
         end
         OpcOpImm: begin
            cand_fmt = FmtI;
            case (funct3)
               3'b000:  dec_op = OpAddi;
               3'b010:  dec_op = OpSlti;
               3'b011:  dec_op = OpSltiu;
               3'b100:  dec_op = OpXori;
               3'b110:  dec_op = OpOri;
               3'b111:  dec_op = OpAndi;
               3'b001: begin
                  cand_fmt = FmtSh;
                  if (funct7 == F7Base) dec_op = OpSlli;
               end
               3'b101: begin
                  cand_fmt = FmtSh;
                  if (funct7 == F7Base) dec_op = OpSrli;
                  else if (funct7 == F7Alt) dec_op = OpSrai;
               end
               default: dec_op = OpInvalid;
            endcase
         end
         OpcOp: begin
            cand_fmt = FmtR;
            if (funct7 == F7Base) begin
               case (funct3)
                  3'b000:  dec_op = OpAdd;
                  3'b001:  dec_op = OpSll;
                  3'b010:  dec_op = OpSlt;
                  3'b011:  dec_op = OpSltu;
                  3'b100:  dec_op = OpXor;
                  3'b101:  dec_op = OpSrl;
                  3'b110:  dec_op = OpOr;
                  default: dec_op = OpAnd;
               endcase
            end else if (funct7 == F7Alt) begin
               case (funct3)
                  3'b000:  dec_op = OpSub;
                  3'b101:  dec_op = OpSra;
                  default: dec_op = OpInvalid;
               endcase
            end
         end
         default: dec_op = OpInvalid;
      endcase
      // An unrecognised funct inside a known opcode exposes no fields
      dec_fmt = (dec_op == OpInvalid) ? FmtNone : cand_fmt;
   end

   // Extract register indices and immediate according to the format
   always_comb begin
      dec_rd  = 5'd0;
      dec_rs1 = 5'd0;
      dec_rs2 = 5'd0;
      dec_imm = 32'd0;
      case (dec_fmt)
         FmtR: begin
            dec_rd  = instr_from_iq[11:7];
            dec_rs1 = instr_from_iq[19:15];
            dec_rs2 = instr_from_iq[24:20];
         end
         FmtI: begin
            dec_rd  = instr_from_iq[11:7];
            dec_rs1 = instr_from_iq[19:15];
            dec_imm = {{20{instr_from_iq[31]}}, instr_from_iq[31:20]};
         end
         FmtSh: begin
            dec_rd  = instr_from_iq[11:7];
            dec_rs1 = instr_from_iq[19:15];
            dec_imm = {27'd0, instr_from_iq[24:20]};
         end
         FmtS: begin
            dec_rs1 = instr_from_iq[19:15];
            dec_rs2 = instr_from_iq[24:20];
            dec_imm = {{20{instr_from_iq[31]}}, instr_from_iq[31:25], instr_from_iq[11:7]};
         end
         FmtB: begin
            dec_rs1 = instr_from_iq[19:15];
            dec_rs2 = instr_from_iq[24:20];
            dec_imm = {{19{instr_from_iq[31]}}, instr_from_iq[31], instr_from_iq[7],
                       instr_from_iq[30:25], instr_from_iq[11:8], 1'b0};
         end
         FmtU: begin
            dec_rd  = instr_from_iq[11:7];
            dec_imm = {instr_from_iq[31:12], 12'd0};
         end
         FmtJ: begin
            dec_rd  = instr_from_iq[11:7];
            dec_imm = {{11{instr_from_iq[31]}}, instr_from_iq[31], instr_from_iq[19:12],
                       instr_from_iq[20], instr_from_iq[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   // Pop handshake and next output-register state; flush overrides everything
   always_comb begin
      take    = !is_empty_from_iq && !is_exception_from_rob && (!valid_q || !is_stall_from_rs);
      valid_d = valid_q;
      op_d    = op_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      if (is_exception_from_rob) begin
         valid_d = 1'b0;
      end else if (take) begin
         valid_d = 1'b1;
         op_d    = dec_op;
         rd_d    = dec_rd;
         rs1_d   = dec_rs1;
         rs2_d   = dec_rs2;
         imm_d   = dec_imm;
         pc_d    = pc_from_iq;
      end else if (valid_q && !is_stall_from_rs) begin
         valid_d = 1'b0;
      end
   end

   // Output register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         op_q    <= 6'd0;
         rd_q    <= 5'd0;
         rs1_q   <= 5'd0;
         rs2_q   <= 5'd0;
         imm_q   <= 32'd0;
         pc_q    <= 32'd0;
      end else begin
         valid_q <= valid_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
      end
   end

   // Pop is suppressed while reset is held so the queue never drains into a cleared stage
   assign is_receive_to_iq = take && !rst;
   assign is_instr_to_rs   = valid_q;
   assign op_to_rs         = op_q;
   assign rd_to_rs         = rd_q;
   assign rs1_to_rs        = rs1_q;
   assign rs2_to_rs        = rs2_q;
   assign imm_to_rs        = imm_q;
   assign pc_to_rs         = pc_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: an instruction-queue model feeds the DUT and a
// scoreboard of hand-derived expected decodes is checked as dispatch consumes them.
module tb_decoder;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        is_empty_from_iq;
   logic [31:0] instr_from_iq;
   logic [31:0] pc_from_iq;
   logic        is_stall_from_rs;
   logic        is_exception_from_rob;
   logic        is_receive_to_iq;
   logic        is_instr_to_rs;
   logic [5:0]  op_to_rs;
   logic [4:0]  rd_to_rs;
   logic [4:0]  rs1_to_rs;
   logic [4:0]  rs2_to_rs;
   logic [31:0] imm_to_rs;
   logic [31:0] pc_to_rs;

   int n_cmp = 0;
   int n_err = 0;

   vec_t src_q[$];  // instruction queue contents not yet popped
   vec_t exp_q[$];  // popped instructions awaiting consumption (0 or 1 entry)

   decoder dut (
      .clk                   (clk),
      .rst                   (rst),
      .is_empty_from_iq      (is_empty_from_iq),
      .instr_from_iq         (instr_from_iq),
      .pc_from_iq            (pc_from_iq),
      .is_stall_from_rs      (is_stall_from_rs),
      .is_exception_from_rob (is_exception_from_rob),
      .is_receive_to_iq      (is_receive_to_iq),
      .is_instr_to_rs        (is_instr_to_rs),
      .op_to_rs              (op_to_rs),
      .rd_to_rs              (rd_to_rs),
      .rs1_to_rs             (rs1_to_rs),
      .rs2_to_rs             (rs2_to_rs),
      .imm_to_rs             (imm_to_rs),
      .pc_to_rs              (pc_to_rs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [5:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm);
      vec_t v;
      v.instr = instr;
      v.pc    = pc;
      v.op    = op;
      v.rd    = rd;
      v.rs1   = rs1;
      v.rs2   = rs2;
      v.imm   = imm;
      return v;
   endfunction

   task automatic drive_inputs();
      is_empty_from_iq = (src_q.size() == 0);
      instr_from_iq    = (src_q.size() != 0) ? src_q[0].instr : 32'd0;
      pc_from_iq       = (src_q.size() != 0) ? src_q[0].pc : 32'd0;
   endtask

   // One clock of traffic: check handshake against the model, score consumption, track pops
   task automatic cycle(input logic stall, input logic exc);
      vec_t e;
      logic m_valid;
      logic m_take;
      is_stall_from_rs      = stall;
      is_exception_from_rob = exc;
      drive_inputs();
      @(negedge clk);
      m_valid = (exp_q.size() != 0);
      m_take  = (src_q.size() != 0) && !exc && (!m_valid || !stall);
      n_cmp++;
      if (is_instr_to_rs !== m_valid) begin
         n_err++;
         $display("FAIL valid t=%0t: got %b want %b", $time, is_instr_to_rs, m_valid);
      end
      n_cmp++;
      if (is_receive_to_iq !== m_take) begin
         n_err++;
         $display("FAIL pop t=%0t: got %b want %b", $time, is_receive_to_iq, m_take);
      end
      if (m_valid && !stall && !exc) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (op_to_rs !== e.op || imm_to_rs !== e.imm || pc_to_rs !== e.pc ||
             (e.op != 6'd0 && {rd_to_rs, rs1_to_rs, rs2_to_rs} !== {e.rd, e.rs1, e.rs2})) begin
            n_err++;
            $display("FAIL decode %08h: got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%08h pc=%08h want op=%0d rd=%0d rs1=%0d rs2=%0d imm=%08h pc=%08h",
                     e.instr, op_to_rs, rd_to_rs, rs1_to_rs, rs2_to_rs, imm_to_rs, pc_to_rs,
                     e.op, e.rd, e.rs1, e.rs2, e.imm, e.pc);
         end
      end
      if (m_take) exp_q.push_back(src_q.pop_front());
      @(posedge clk);
      #1;
      if (exc) exp_q.delete();
      is_exception_from_rob = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (src_q.size() != 0 || exp_q.size() != 0); i++) cycle(1'b0, 1'b0);
      n_cmp++;
      if (src_q.size() != 0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", src_q.size() + exp_q.size());
         src_q.delete();
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      is_stall_from_rs = 1'b0;
      is_exception_from_rob = 1'b0;
      src_q.push_back(mk(32'h00500093, 32'h0, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5));
      drive_inputs();
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if ({is_instr_to_rs, op_to_rs, rd_to_rs, rs1_to_rs, rs2_to_rs, imm_to_rs, pc_to_rs} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b op=%0d imm=%08h pc=%08h want all 0",
                     is_instr_to_rs, op_to_rs, imm_to_rs, pc_to_rs);
         end
         n_cmp++;
         if (is_receive_to_iq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pop: got %b want 0", is_receive_to_iq);
         end
      end
      @(posedge clk);
      #1;
      src_q.delete();
      drive_inputs();
      rst = 1'b0;
   endtask

   task automatic test_decode();
      src_q.push_back(mk(32'h00500093, 32'h00000000, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5));
      src_q.push_back(mk(32'hFE000EE3, 32'h00000004, 6'd5,  5'd0, 5'd0, 5'd0, 32'hFFFFFFFC));
      src_q.push_back(mk(32'h123452B7, 32'h00000008, 6'd1,  5'd5, 5'd0, 5'd0, 32'h12345000));
      src_q.push_back(mk(32'h0020A423, 32'h0000000C, 6'd18, 5'd0, 5'd1, 5'd2, 32'd8));
      src_q.push_back(mk(32'h402081B3, 32'h00000010, 6'd29, 5'd3, 5'd1, 5'd2, 32'd0));
      src_q.push_back(mk(32'h0000007F, 32'h00000014, 6'd0,  5'd0, 5'd0, 5'd0, 32'd0));
      src_q.push_back(mk(32'h008000EF, 32'h00000018, 6'd3,  5'd1, 5'd0, 5'd0, 32'd8));
      src_q.push_back(mk(32'h00001517, 32'h0000001C, 6'd2,  5'd10, 5'd0, 5'd0, 32'h00001000));
      src_q.push_back(mk(32'h4030D193, 32'h00000020, 6'd27, 5'd3, 5'd1, 5'd0, 32'd3));
      src_q.push_back(mk(32'h02000033, 32'h00000024, 6'd0,  5'd0, 5'd0, 5'd0, 32'd0));
      src_q.push_back(mk(32'hFFF14083, 32'h00000028, 6'd14, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF));
      drain();
   endtask

   task automatic test_back_to_back();
      int cycles;
      cycles = 0;
      for (int i = 0; i < 5; i++)
         src_q.push_back(mk(32'h003100B3, 32'h100 + 32'(4 * i), 6'd28, 5'd1, 5'd2, 5'd3, 32'd0));
      for (int i = 0; i < 40 && (src_q.size() != 0 || exp_q.size() != 0); i++) begin
         cycle(1'b0, 1'b0);
         cycles++;
      end
      n_cmp++;
      if (cycles != 6) begin
         n_err++;
         $display("FAIL throughput: got %0d cycles want 6", cycles);
      end
      drain();
   endtask

   task automatic test_stall();
      vec_t held;
      src_q.push_back(mk(32'h00500093, 32'h200, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5));
      src_q.push_back(mk(32'h123452B7, 32'h204, 6'd1,  5'd5, 5'd0, 5'd0, 32'h12345000));
      src_q.push_back(mk(32'h0020A423, 32'h208, 6'd18, 5'd0, 5'd1, 5'd2, 32'd8));
      src_q.push_back(mk(32'h402081B3, 32'h20C, 6'd29, 5'd3, 5'd1, 5'd2, 32'd0));
      cycle(1'b0, 1'b0);
      held = src_q.size() == 3 ? exp_q[0] : '0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0);
         n_cmp++;
         if ({op_to_rs, rd_to_rs, imm_to_rs, pc_to_rs} !== {held.op, held.rd, held.imm, held.pc} ||
             src_q.size() != 3) begin
            n_err++;
            $display("FAIL stall_hold: got op=%0d pc=%08h iq=%0d want op=%0d pc=%08h iq=3",
                     op_to_rs, pc_to_rs, src_q.size(), held.op, held.pc);
         end
      end
      drain();
   endtask

   task automatic test_flush();
      src_q.push_back(mk(32'h00500093, 32'h300, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5));
      src_q.push_back(mk(32'h123452B7, 32'h304, 6'd1,  5'd5, 5'd0, 5'd0, 32'h12345000));
      src_q.push_back(mk(32'h008000EF, 32'h308, 6'd3,  5'd1, 5'd0, 5'd0, 32'd8));
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);  // flush with a would-be pop
      n_cmp++;
      if (is_instr_to_rs !== 1'b0) begin
         n_err++;
         $display("FAIL flush_valid: got %b want 0", is_instr_to_rs);
      end
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b1);  // flush while stalled discards the held entry
      n_cmp++;
      if (is_instr_to_rs !== 1'b0 || src_q.size() != 1) begin
         n_err++;
         $display("FAIL flush_stalled: got v=%b iq=%0d want v=0 iq=1", is_instr_to_rs, src_q.size());
      end
      drain();
   endtask

   task automatic test_reset_mid();
      src_q.push_back(mk(32'h4030D193, 32'h400, 6'd27, 5'd3, 5'd1, 5'd0, 32'd3));
      src_q.push_back(mk(32'h00500093, 32'h404, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5));
      cycle(1'b0, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({is_instr_to_rs, is_receive_to_iq, op_to_rs, rd_to_rs, rs1_to_rs, rs2_to_rs,
           imm_to_rs, pc_to_rs} !== '0) begin
         n_err++;
         $display("FAIL reset_mid: got v=%b pop=%b op=%0d imm=%08h pc=%08h want all 0",
                  is_instr_to_rs, is_receive_to_iq, op_to_rs, imm_to_rs, pc_to_rs);
      end
      src_q.delete();
      exp_q.delete();
      drive_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
